// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the core's I/D request ports, the shared memory port and the arbiter.
// Modports: slave = the arbiter; master = the core plus memory side that drives requests and the memory response.
// Parameters: ADDR_W/DATA_W must match the mem_port_arbiter instance that uses this bundle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    // Load/store side
    logic              d_req;
    logic              d_rd_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    // Shared memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_rd_wr;
    logic              mem_enable;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_rd_wr, d_addr, d_wdata, d_size,
        input  mem_rdata, mem_busy,
        output i_rdata, i_ack,
        output d_rdata, d_ack, d_err,
        output mem_addr, mem_wdata, mem_size, mem_rd_wr, mem_enable
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_rd_wr, d_addr, d_wdata, d_size,
        output mem_rdata, mem_busy,
        input  i_rdata, i_ack,
        input  d_rdata, d_ack, d_err,
        input  mem_addr, mem_wdata, mem_size, mem_rd_wr, mem_enable
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-fetch and D load/store sides, one transaction at a time.
// D has priority, but after STARVE_MAX consecutive D grants with i_req pending, I is forced.
// Ports: clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave: I/D requests and memory port).
// Latency: request seen in IDLE -> mem_enable next cycle -> ack one cycle later plus one per mem_busy cycle.
// Backpressure: requesters hold req/fields until their one-cycle ack; mem_busy stretches the BUSY phase.
// Optional macro ARB_ALIGN_CHECK_EN: misaligned D requests are answered with d_ack+d_err without touching memory.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    // Size encoding: 0 = byte, 1 = half, 2 = word.
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam int         CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [1:0]        mem_size_q,   mem_size_d;
    logic              mem_rd_wr_q,  mem_rd_wr_d;
    logic              mem_enable_q, mem_enable_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              i_ack_q,      i_ack_d;
    logic              d_ack_q,      d_ack_d;
    logic              d_err_q,      d_err_d;
    logic              win_d_q,      win_d_d;   // 1 = current transaction belongs to D
    logic [CNT_W-1:0]  cnt_q,        cnt_d;     // consecutive D grants while I waited

    logic any_req;
    logic grant_d;
    logic d_misaligned;

    assign any_req = bus.i_req | bus.d_req;
    // D wins unless I has already been passed over STARVE_MAX times in a row.
    assign grant_d = bus.d_req && ((cnt_q < CNT_MAX) || !bus.i_req);

`ifdef ARB_ALIGN_CHECK_EN
    localparam logic [1:0] SZ_HALF = 2'd1;
    assign d_misaligned = ((bus.d_size == SZ_WORD) && (bus.d_addr[1:0] != 2'b00)) ||
                          ((bus.d_size == SZ_HALF) && bus.d_addr[0]);
`else
    assign d_misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    // A misaligned D request never reaches memory: answer straight away.
                    state_d = (grant_d && d_misaligned) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (!bus.mem_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        mem_rd_wr_d  = mem_rd_wr_q;
        mem_enable_d = mem_enable_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        win_d_d      = win_d_q;
        cnt_d        = cnt_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.i_req) begin
                    cnt_d = '0;
                end
                if (grant_d) begin
                    win_d_d = 1'b1;
                    if (bus.i_req && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (d_misaligned) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                    end else begin
                        mem_addr_d   = bus.d_addr;
                        mem_wdata_d  = bus.d_wdata;
                        mem_size_d   = bus.d_size;
                        mem_rd_wr_d  = bus.d_rd_wr;
                        mem_enable_d = 1'b1;
                    end
                end else if (bus.i_req) begin
                    win_d_d      = 1'b0;
                    cnt_d        = '0;
                    mem_addr_d   = bus.i_addr;
                    mem_size_d   = SZ_WORD;
                    mem_rd_wr_d  = 1'b1;
                    mem_enable_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (!bus.mem_busy) begin
                    mem_enable_d = 1'b0;
                    if (win_d_q) begin
                        d_ack_d = 1'b1;
                        // Stores leave the load-data register untouched.
                        if (mem_rd_wr_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
            mem_rd_wr_q  <= 1'b1;
            mem_enable_q <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            win_d_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            mem_enable_q <= mem_enable_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            win_d_q      <= win_d_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_size   = mem_size_q;
    assign bus.mem_rd_wr  = mem_rd_wr_q;
    assign bus.mem_enable = mem_enable_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.i_ack      = i_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.d_err      = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand sequences, then random traffic
// against a transaction-level model (grant rule, latency arithmetic, expected data per address).
// Memory responder stretches each enable by busy_len cycles and returns a per-address word.
module tb_mem_port_arbiter;
    localparam int STARVE = 4;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int cyc;

    // Memory responder controls
    int          busy_len;
    bit          rd_fixed_en;
    logic [31:0] rd_fixed;
    int          rsp_k;
    bit          rsp_prev;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

`ifdef ARB_ALIGN_CHECK_EN
    function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
        return ((sz == 2'd2) && (a[1:0] != 2'b00)) || ((sz == 2'd1) && a[0]);
    endfunction
`endif

    always @(posedge clk) begin
        #2;
        if (bus.mem_enable) begin
            if (!rsp_prev) rsp_k = 0;
            else rsp_k = rsp_k + 1;
            if (rsp_k < busy_len) begin
                bus.mem_busy  = 1'b1;
                bus.mem_rdata = $urandom;
            end else begin
                bus.mem_busy  = 1'b0;
                bus.mem_rdata = rd_fixed_en ? rd_fixed : hash(bus.mem_addr);
            end
        end else begin
            bus.mem_busy  = 1'b0;
            bus.mem_rdata = $urandom;
        end
        rsp_prev = bus.mem_enable;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1 ({tag, "_mem_enable"}, bus.mem_enable, 1'b0);
        chk1 ({tag, "_i_ack"},      bus.i_ack,      1'b0);
        chk1 ({tag, "_d_ack"},      bus.d_ack,      1'b0);
        chk1 ({tag, "_d_err"},      bus.d_err,      1'b0);
        chk1 ({tag, "_mem_rd_wr"},  bus.mem_rd_wr,  1'b1);
        chk32({tag, "_mem_addr"},   bus.mem_addr,   32'h0);
        chk32({tag, "_mem_wdata"},  bus.mem_wdata,  32'h0);
        chk32({tag, "_mem_size"},   32'(bus.mem_size), 32'h0);
        chk32({tag, "_i_rdata"},    bus.i_rdata,    32'h0);
        chk32({tag, "_d_rdata"},    bus.d_rdata,    32'h0);
    endtask

    typedef struct {
        bit          is_d;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          busy;
        logic [31:0] mem_data;
        int          exp_lat;
        bit          exp_rd_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [6];

    // Scratch and model state
    int          n0, k, first_d, first_i, nack, b;
    bit          overlap;
    int          arb_c, ack_c, en_s, en_e, g_c, cnt_m;
    bit          cur_d, cur_rd, cur_err, ip, dp, e_en, granted;
    logic [31:0] cur_addr, cur_wdata, exp_d_rdata;
    logic [1:0]  cur_size;

    initial begin
        tests = 0; fails = 0; cyc = 0;
        busy_len = 0; rd_fixed_en = 1'b0; rd_fixed = 32'h0;
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_rd_wr = 1'b1; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = 2'd2;

        //          is_d rd  addr          wdata         sz    busy data          lat rw  esz   exp_rdata
        vt[0] = '{1'b0, 1'b1, 32'h8002_0000, 32'h0,         2'd0, 0, 32'h2402_0005, 2, 1'b1, 2'd2, 32'h2402_0005};
        vt[1] = '{1'b1, 1'b1, 32'h8002_1000, 32'h0,         2'd2, 0, 32'h1122_3344, 2, 1'b1, 2'd2, 32'h1122_3344};
        vt[2] = '{1'b1, 1'b0, 32'h8002_1004, 32'hDEAD_BEEF, 2'd2, 1, 32'hCAFE_F00D, 3, 1'b0, 2'd2, 32'h1122_3344};
        vt[3] = '{1'b0, 1'b1, 32'h8002_0004, 32'h0,         2'd0, 3, 32'h8C01_0000, 5, 1'b1, 2'd2, 32'h8C01_0000};
        vt[4] = '{1'b1, 1'b1, 32'h8002_1002, 32'h0,         2'd1, 2, 32'h0000_BEEF, 4, 1'b1, 2'd1, 32'h0000_BEEF};
        vt[5] = '{1'b1, 1'b1, 32'h8002_1003, 32'h0,         2'd0, 0, 32'h0000_00AB, 2, 1'b1, 2'd0, 32'h0000_00AB};

        step(); step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step(); step();
        chk1("idle_no_enable", bus.mem_enable, 1'b0);

        // ---------------- vector table ----------------
        for (int v = 0; v < 6; v++) begin
            idle(2);
            busy_len = vt[v].busy; rd_fixed_en = 1'b1; rd_fixed = vt[v].mem_data;
            bus.d_size = vt[v].size;
            if (vt[v].is_d) begin
                bus.d_req = 1'b1; bus.d_rd_wr = vt[v].rd; bus.d_addr = vt[v].addr; bus.d_wdata = vt[v].wdata;
            end else begin
                bus.i_req = 1'b1; bus.i_addr = vt[v].addr;
            end
            n0 = cyc;
            step();
            chk1 ("vec_enable",    bus.mem_enable, 1'b1);
            chk32("vec_mem_addr",  bus.mem_addr, vt[v].addr);
            chk1 ("vec_mem_rd_wr", bus.mem_rd_wr, vt[v].exp_rd_wr);
            chk32("vec_mem_size",  32'(bus.mem_size), 32'(vt[v].exp_size));
            if (vt[v].is_d && !vt[v].rd) chk32("vec_mem_wdata", bus.mem_wdata, vt[v].wdata);
            // Fields changed after the grant must not leak into the transaction.
            bus.i_addr = ~vt[v].addr; bus.d_addr = ~vt[v].addr; bus.d_wdata = $urandom;
            k = 0;
            while (!(bus.i_ack || bus.d_ack) && k < 20) begin
                chk1 ("vec_hold_enable", bus.mem_enable, 1'b1);
                chk32("vec_hold_addr",   bus.mem_addr, vt[v].addr);
                step();
                k++;
            end
            chk1 ("vec_ack_seen", bus.i_ack || bus.d_ack, 1'b1);
            chk32("vec_latency",  cyc - n0, vt[v].exp_lat);
            chk1 ("vec_i_ack",    bus.i_ack, !vt[v].is_d);
            chk1 ("vec_d_ack",    bus.d_ack, vt[v].is_d);
            chk1 ("vec_d_err",    bus.d_err, 1'b0);
            chk1 ("vec_enable_off", bus.mem_enable, 1'b0);
            if (vt[v].is_d) chk32("vec_d_rdata", bus.d_rdata, vt[v].exp_rdata);
            else            chk32("vec_i_rdata", bus.i_rdata, vt[v].exp_rdata);
        end
        rd_fixed_en = 1'b0;

        // ---------------- simultaneous requests: D write first, then I ----------------
        idle(2);
        busy_len = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h8002_0000;
        bus.d_req = 1'b1; bus.d_rd_wr = 1'b0; bus.d_addr = 32'h8002_1000;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_size = 2'd2;
        n0 = cyc; first_d = -1; first_i = -1; overlap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cyc == n0 + 1) begin
                chk1 ("both_first_rd_wr", bus.mem_rd_wr, 1'b0);
                chk32("both_first_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            end
            if (bus.i_ack && bus.d_ack) overlap = 1'b1;
            if (bus.d_ack && first_d < 0) begin first_d = cyc - n0; bus.d_req = 1'b0; end
            if (bus.i_ack && first_i < 0) begin
                first_i = cyc - n0; bus.i_req = 1'b0;
                chk32("both_i_rdata", bus.i_rdata, hash(32'h8002_0000));
            end
        end
        chk32("both_d_ack_cycle", first_d, 2);
        chk32("both_i_ack_cycle", first_i, 5);
        chk1 ("both_no_overlap",  overlap, 1'b0);

        // ---------------- starvation: both held high ----------------
        idle(2);
        bus.i_req = 1'b1; bus.i_addr = 32'h8002_0100;
        bus.d_req = 1'b1; bus.d_rd_wr = 1'b1; bus.d_addr = 32'h8002_2000; bus.d_size = 2'd2;
        nack = 0;
        for (int i = 0; i < 80 && nack < 10; i++) begin
            step();
            if (bus.i_ack || bus.d_ack) begin
                chk1("starve_order_d", bus.d_ack, (nack % (STARVE + 1)) != STARVE);
                nack++;
            end
        end
        chk32("starve_ack_count", nack, 10);

        // ---------------- reset in the middle of BUSY ----------------
        idle(2);
        busy_len = 6;
        bus.i_req = 1'b1; bus.i_addr = 32'h8002_0010;
        n0 = cyc;
        step(); step();
        chk1("rst_pre_enable", bus.mem_enable, 1'b1);
        reset = 1'b1; busy_len = 0;
        step();
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        step();
        chk1 ("rst_after_enable", bus.mem_enable, 1'b1);
        chk32("rst_after_addr",   bus.mem_addr, 32'h8002_0010);
        chk1 ("rst_after_no_ack", bus.i_ack, 1'b0);
        step();
        chk1 ("rst_after_i_ack",  bus.i_ack, 1'b1);
        chk32("rst_after_rdata",  bus.i_rdata, hash(32'h8002_0010));
        bus.i_req = 1'b0;

`ifdef ARB_ALIGN_CHECK_EN
        // ---------------- misaligned D request skips memory ----------------
        idle(2);
        bus.d_req = 1'b1; bus.d_rd_wr = 1'b1; bus.d_size = 2'd2; bus.d_addr = 32'h8002_1002;
        step();
        chk1("mis_d_ack",  bus.d_ack, 1'b1);
        chk1("mis_d_err",  bus.d_err, 1'b1);
        chk1("mis_no_enable", bus.mem_enable, 1'b0);
        bus.d_req = 1'b0;
        step();
        chk1("mis_ack_clear", bus.d_ack, 1'b0);
        chk1("mis_no_enable2", bus.mem_enable, 1'b0);
`endif

        // ---------------- random traffic against transaction model ----------------
        idle(2);
        cnt_m = 0; arb_c = cyc + 1; ack_c = -1; en_s = 1; en_e = 0; g_c = -1;
        exp_d_rdata = 32'h0; ip = 1'b0; dp = 1'b0; cur_d = 1'b0; cur_err = 1'b0;
        cur_rd = 1'b1; cur_addr = '0; cur_wdata = '0; cur_size = 2'd2;
        for (int it = 0; it < 2000; it++) begin
            step();
            e_en = (cyc >= en_s) && (cyc <= en_e);
            chk1("rnd_mem_enable", bus.mem_enable, e_en);
            chk1("rnd_i_ack", bus.i_ack, (cyc == ack_c) && !cur_d);
            chk1("rnd_d_ack", bus.d_ack, (cyc == ack_c) && cur_d);
            chk1("rnd_d_err", bus.d_err, (cyc == ack_c) && cur_d && cur_err);
            if (e_en) begin
                chk32("rnd_mem_addr",  bus.mem_addr, cur_addr);
                chk1 ("rnd_mem_rd_wr", bus.mem_rd_wr, cur_rd);
                chk32("rnd_mem_size",  32'(bus.mem_size), 32'(cur_size));
                if (cur_d && !cur_rd) chk32("rnd_mem_wdata", bus.mem_wdata, cur_wdata);
            end
            if (cyc == ack_c) begin
                if (cur_d) begin
                    if (cur_rd && !cur_err) exp_d_rdata = hash(cur_addr);
                    chk32("rnd_d_rdata", bus.d_rdata, exp_d_rdata);
                    dp = 1'b0;
                end else begin
                    chk32("rnd_i_rdata", bus.i_rdata, hash(cur_addr));
                    ip = 1'b0;
                end
            end
            // Granted requester scribbles over its fields while waiting.
            if (cyc > g_c && cyc < ack_c) begin
                if (cur_d) begin
                    bus.d_addr = $urandom; bus.d_wdata = $urandom;
                    bus.d_rd_wr = 1'($urandom_range(0, 1)); bus.d_size = 2'($urandom_range(0, 2));
                end else begin
                    bus.i_addr = $urandom;
                end
            end
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1'b1; bus.i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1; bus.d_addr = $urandom; bus.d_wdata = $urandom;
                bus.d_rd_wr = 1'($urandom_range(0, 1)); bus.d_size = 2'($urandom_range(0, 2));
            end
            bus.i_req = ip; bus.d_req = dp;
            if (cyc == arb_c) begin
                granted = 1'b1;
                if (!ip) cnt_m = 0;
                if (dp && (cnt_m < STARVE || !ip)) begin
                    cur_d = 1'b1; cur_rd = bus.d_rd_wr; cur_addr = bus.d_addr;
                    cur_wdata = bus.d_wdata; cur_size = bus.d_size;
                    if (ip) cnt_m = (cnt_m < STARVE) ? cnt_m + 1 : STARVE;
                end else if (ip) begin
                    cur_d = 1'b0; cur_rd = 1'b1; cur_addr = bus.i_addr; cur_size = 2'd2;
                    cnt_m = 0;
                end else begin
                    granted = 1'b0;
                    arb_c = cyc + 1;
                end
                if (granted) begin
                    g_c = cyc;
                    cur_err = 1'b0;
`ifdef ARB_ALIGN_CHECK_EN
                    if (cur_d) cur_err = misaligned(cur_size, cur_addr);
`endif
                    if (cur_err) begin
                        en_s = 1; en_e = 0;
                        ack_c = cyc + 1; arb_c = cyc + 2;
                    end else begin
                        b = $urandom_range(0, 3);
                        busy_len = b;
                        en_s = cyc + 1; en_e = cyc + 1 + b;
                        ack_c = cyc + 2 + b; arb_c = cyc + 3 + b;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
